// File: rtl/proc_param_if.sv
// Memory bus between proc_param (master) and its instruction/data memory (slave).
interface proc_param_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [DW-1:0] DIN;
  logic          DIN_valid;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DOUT;
  logic          W;

  modport master (
    input  DIN,
    input  DIN_valid,
    output ADDR,
    output DOUT,
    output W
  );

  modport slave (
    output DIN,
    output DIN_valid,
    input  ADDR,
    input  DOUT,
    input  W
  );
endinterface

// File: rtl/proc_param.sv
// Multi-cycle 9-bit-instruction processor, R0 is the PC, memory via proc_param_if.
// Optional macro PROC_AND_EN turns opcode 7 into a bitwise and; otherwise it is a NOP.
module proc_param #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  proc_param_if.master  bus,
  output logic          Done,
  output logic [2:0]    Tstep_Q,
  output logic [DW-1:0] R0
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IRLD  = 3'd1,
    S_EX1   = 3'd2,
    S_EX2   = 3'd3,
    S_EX3   = 3'd4,
    S_IDLE  = 3'd5
  } state_e;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  state_e        state_q, state_d;
  logic [DW-1:0] r_q [8];
  logic [DW-1:0] r_d [8];
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] g_q, g_d;
  logic [8:0]    ir_q, ir_d;
  logic          z_q, z_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          w_q, w_d;

  logic [2:0]    op_s, rx_s, ry_s;
  logic [DW-1:0] alu_s;
  state_e        after_done_s;

  assign op_s = ir_q[8:6];
  assign rx_s = ir_q[5:3];
  assign ry_s = ir_q[2:0];

  // Run is only consulted when an instruction finishes (or while idle).
  assign after_done_s = Run ? S_FETCH : S_IDLE;

  // ALU result for the second execute step of add/sub/and
  always_comb begin
    alu_s = '0;
    case (op_s)
      OP_ADD:  alu_s = a_q + r_q[ry_s];
      OP_SUB:  alu_s = a_q - r_q[ry_s];
      OP_AND:  alu_s = a_q & r_q[ry_s];
      default: alu_s = '0;
    endcase
  end

  // Next-state and datapath control; everything holds unless a step updates it
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    g_d     = g_q;
    ir_d    = ir_q;
    z_d     = z_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    w_d     = w_q;
    Done    = 1'b0;

    case (state_q)
      S_IDLE, S_FETCH: begin
        if (Run) begin
          addr_d  = r_q[0][AW-1:0];
          r_d[0]  = r_q[0] + DW'(1);
          state_d = S_IRLD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_IRLD: begin
        if (bus.DIN_valid) begin
          ir_d    = bus.DIN[8:0];
          state_d = S_EX1;
        end else begin
          state_d = S_IRLD;
        end
      end

      S_EX1: begin
        case (op_s)
          OP_MV: begin
            r_d[rx_s] = r_q[ry_s];
            Done      = 1'b1;
            state_d   = after_done_s;
          end
          OP_MVNZ: begin
            if (!z_q) begin
              r_d[rx_s] = r_q[ry_s];
            end else begin
              r_d[rx_s] = r_q[rx_s];
            end
            Done    = 1'b1;
            state_d = after_done_s;
          end
          OP_MVI: begin
            addr_d  = r_q[0][AW-1:0];
            r_d[0]  = r_q[0] + DW'(1);
            state_d = S_EX2;
          end
          OP_LD: begin
            addr_d  = r_q[ry_s][AW-1:0];
            state_d = S_EX2;
          end
          OP_ST: begin
            addr_d  = r_q[ry_s][AW-1:0];
            dout_d  = r_q[rx_s];
            w_d     = 1'b1;
            state_d = S_EX2;
          end
          OP_ADD, OP_SUB: begin
            a_d     = r_q[rx_s];
            state_d = S_EX2;
          end
`ifdef PROC_AND_EN
          OP_AND: begin
            a_d     = r_q[rx_s];
            state_d = S_EX2;
          end
`else
          OP_AND: begin
            Done    = 1'b1;
            state_d = after_done_s;
          end
`endif
          default: begin
            Done    = 1'b1;
            state_d = after_done_s;
          end
        endcase
      end

      S_EX2: begin
        case (op_s)
          OP_MVI, OP_LD: begin
            if (bus.DIN_valid) begin
              r_d[rx_s] = bus.DIN;
              Done      = 1'b1;
              state_d   = after_done_s;
            end else begin
              state_d = S_EX2;
            end
          end
          OP_ST: begin
            w_d     = 1'b0;
            Done    = 1'b1;
            state_d = after_done_s;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            g_d     = alu_s;
            z_d     = (alu_s == '0);
            state_d = S_EX3;
          end
          default: begin
            Done    = 1'b1;
            state_d = after_done_s;
          end
        endcase
      end

      S_EX3: begin
        r_d[rx_s] = g_q;
        Done      = 1'b1;
        state_d   = after_done_s;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= '0;
      end
      a_q    <= '0;
      g_q    <= '0;
      ir_q   <= 9'd0;
      z_q    <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      w_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= r_d[i];
      end
      a_q    <= a_d;
      g_q    <= g_d;
      ir_q   <= ir_d;
      z_q    <= z_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      w_q    <= w_d;
    end
  end

  assign Tstep_Q  = state_q;
  assign R0       = r_q[0];
  assign bus.ADDR = addr_q;
  assign bus.DOUT = dout_q;
  assign bus.W    = w_q;

endmodule

// File: tb/tb_proc_param.sv
// Bench for proc_param: directed scenarios plus a randomized program checked
// against an instruction-level model of the processor.
module tb_proc_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, dinv, run9;
  logic        done, done9;
  logic [2:0]  ts, ts9;
  logic [15:0] r0;
  logic [8:0]  r0_9;

  always #5 clk = ~clk;

  proc_param_if #(.DW(16), .AW(16)) bus16 ();
  proc_param_if #(.DW(9),  .AW(9))  bus9 ();

  proc_param #(.DW(16), .AW(16)) u_dut (
    .Clock(clk), .Resetn(rst_n), .Run(run), .bus(bus16),
    .Done(done), .Tstep_Q(ts), .R0(r0)
  );

  proc_param #(.DW(9), .AW(9)) u_dut9 (
    .Clock(clk), .Resetn(rst_n), .Run(run9), .bus(bus9),
    .Done(done9), .Tstep_Q(ts9), .R0(r0_9)
  );

  // Memory seen by the 16-bit DUT; bench preloads go through the same port.
  logic [15:0] mem [65536];
  logic        ld_en = 1'b0;
  logic [15:0] ld_a, ld_d;
  assign bus16.DIN       = mem[bus16.ADDR];
  assign bus16.DIN_valid = dinv;
  always @(posedge clk) begin
    if (bus16.W) mem[bus16.ADDR] <= bus16.DOUT;
    else if (ld_en) mem[ld_a] <= ld_d;
  end

  logic [8:0] mem9 [512];
  assign bus9.DIN       = mem9[bus9.ADDR];
  assign bus9.DIN_valid = 1'b1;

  // Instruction-level reference model
  logic [15:0] mm [65536];
  logic [15:0] mr [8];
  logic        mz;
  logic [15:0] st_q [$];

  int vectors = 0;
  int errors  = 0;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    enc = {7'd0, op, x, y};
  endfunction

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d; mm[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic reset_begin();
    rst_n = 1'b0; run = 1'b0; run9 = 1'b0; dinv = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_end();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mr[i] = 16'd0;
    mz = 1'b0;
  endtask

  // Executes one instruction on the model; returns Done cycle without stalls.
  task automatic model_step(output int base, output bit waits);
    logic [8:0]  ir;
    logic [2:0]  op, x, y;
    logic [15:0] d, res;
    ir = mm[mr[0]][8:0];
    mr[0] = mr[0] + 16'd1;
    op = ir[8:6]; x = ir[5:3]; y = ir[2:0];
    base = 3; waits = 1'b0;
    case (op)
      3'd0: mr[x] = mr[y];
      3'd1: begin d = mm[mr[0]]; mr[0] = mr[0] + 16'd1; mr[x] = d; base = 4; waits = 1'b1; end
      3'd2: begin res = mr[x] + mr[y]; mz = (res == 16'd0); mr[x] = res; base = 5; end
      3'd3: begin res = mr[x] - mr[y]; mz = (res == 16'd0); mr[x] = res; base = 5; end
      3'd4: begin mr[x] = mm[mr[y]]; base = 4; waits = 1'b1; end
      3'd5: begin mm[mr[y]] = mr[x]; st_q.push_back(mr[y]); base = 4; end
      3'd6: if (!mz) mr[x] = mr[y];
      default: begin
`ifdef PROC_AND_EN
        res = mr[x] & mr[y]; mz = (res == 16'd0); mr[x] = res; base = 5;
`endif
      end
    endcase
  endtask

  // Runs one instruction from FETCH/IDLE; DIN_valid held low k1 cycles in the
  // fetch wait and k2 cycles in the data wait. Returns the cycle Done was seen.
  task automatic exec_instr(input int k1, input int k2, output int dc);
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      dinv = !((c >= 2 && c <= 1 + k1) || (c >= 4 + k1 && c <= 3 + k1 + k2));
      #1;
      if (done) begin
        dc = c;
        @(posedge clk); @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int b, dc; bit w;
    reset_begin();
    load(16'd0, enc(3'd1, 3'd1, 3'd0));
    load(16'd1, 16'h0005);
    reset_end();
    #1;
    vectors++; if (ts !== 3'd5) begin errors++; $display("FAIL reset_tstep got %0d want 5", ts); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (r0 !== 16'd0) begin errors++; $display("FAIL reset_r0 got %h want 0", r0); end
    vectors++; if (bus16.ADDR !== 16'd0 || bus16.DOUT !== 16'd0 || bus16.W !== 1'b0) begin
      errors++; $display("FAIL reset_bus got addr=%h dout=%h w=%b want 0", bus16.ADDR, bus16.DOUT, bus16.W); end
    @(negedge clk);
    run = 1'b1;
    model_step(b, w);
    exec_instr(0, 0, dc);
    vectors++; if (dc !== 4) begin errors++; $display("FAIL mvi_done_cycle got %0d want 4", dc); end
    vectors++; if (u_dut.r_q[1] !== 16'h0005) begin errors++; $display("FAIL mvi_r1 got %h want 0005", u_dut.r_q[1]); end
    vectors++; if (r0 !== 16'd2) begin errors++; $display("FAIL mvi_r0 got %h want 0002", r0); end
    vectors++; if (done !== 1'b0 || ts !== 3'd0) begin errors++; $display("FAIL mvi_after got done=%b ts=%0d want 0/0", done, ts); end
  endtask

  task automatic test_stall();
    int b; bit w;
    reset_begin();
    load(16'd0, enc(3'd1, 3'd3, 3'd0));
    load(16'd1, 16'h1234);
    reset_end();
    model_step(b, w);
    run = 1'b1; dinv = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (ts !== 3'd1 || r0 !== 16'd1 || bus16.ADDR !== 16'd0 || done !== 1'b0) begin
        errors++; $display("FAIL irld_stall got ts=%0d r0=%h addr=%h done=%b want 1/0001/0000/0", ts, r0, bus16.ADDR, done); end
      @(negedge clk);
    end
    dinv = 1'b1;
    @(negedge clk);
    vectors++; if (ts !== 3'd2) begin errors++; $display("FAIL irld_resume got ts=%0d want 2", ts); end
    run = 1'b0; dinv = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (ts !== 3'd3 || done !== 1'b0 || u_dut.r_q[3] !== 16'd0 || r0 !== 16'd2) begin
        errors++; $display("FAIL ex2_stall got ts=%0d done=%b r3=%h r0=%h want 3/0/0000/0002", ts, done, u_dut.r_q[3], r0); end
      @(negedge clk);
    end
    dinv = 1'b1; #1;
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL ex2_done got %b want 1", done); end
    @(negedge clk);
    vectors++; if (ts !== 3'd5) begin errors++; $display("FAIL run_low_idle got ts=%0d want 5", ts); end
    vectors++; if (u_dut.r_q[3] !== mr[3] || r0 !== mr[0]) begin
      errors++; $display("FAIL stall_result got r3=%h r0=%h want %h/%h", u_dut.r_q[3], r0, mr[3], mr[0]); end
  endtask

  task automatic test_sub_branch();
    int b, dc, k1, k2; bit w;
    logic [15:0] r3v;
    for (int p = 0; p < 2; p++) begin
      r3v = (p == 0) ? 16'd3 : 16'd1;
      reset_begin();
      load(16'd0, enc(3'd1, 3'd2, 3'd0)); load(16'd1, 16'd3);
      load(16'd2, enc(3'd1, 3'd3, 3'd0)); load(16'd3, r3v);
      load(16'd4, enc(3'd1, 3'd4, 3'd0)); load(16'd5, 16'h0100);
      load(16'd6, enc(3'd3, 3'd2, 3'd3)); load(16'd7, enc(3'd6, 3'd0, 3'd4));
      reset_end();
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
        model_step(b, w);
        k1 = $urandom_range(0, 2); k2 = $urandom_range(0, 2);
        exec_instr(k1, k2, dc);
        vectors++; if (dc !== b + k1 + (w ? k2 : 0)) begin
          errors++; $display("FAIL branch_latency instr %0d got %0d want %0d", i, dc, b + k1 + (w ? k2 : 0)); end
      end
      vectors++; if (u_dut.r_q[2] !== ((p == 0) ? 16'd0 : 16'd2)) begin
        errors++; $display("FAIL sub_result p%0d got %h", p, u_dut.r_q[2]); end
      vectors++; if (u_dut.z_q !== (p == 0)) begin errors++; $display("FAIL sub_z p%0d got %b", p, u_dut.z_q); end
      vectors++; if (r0 !== ((p == 0) ? 16'd8 : 16'h0100)) begin
        errors++; $display("FAIL mvnz_pc p%0d got %h", p, r0); end
    end
  endtask

  task automatic test_store();
    int b, dc; bit w;
    reset_begin();
    load(16'd0, enc(3'd1, 3'd5, 3'd0)); load(16'd1, 16'hABCD);
    load(16'd2, enc(3'd1, 3'd6, 3'd0)); load(16'd3, 16'h0040);
    load(16'd4, enc(3'd5, 3'd5, 3'd6));
    reset_end();
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin model_step(b, w); exec_instr(0, 0, dc); end
    model_step(b, w);
    dinv = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (ts !== 3'd2 || bus16.W !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL st_ex1 got ts=%0d w=%b done=%b want 2/0/0", ts, bus16.W, done); end
    run = 1'b0;
    @(negedge clk); #1;
    vectors++; if (bus16.W !== 1'b1 || bus16.ADDR !== 16'h0040 || bus16.DOUT !== 16'hABCD) begin
      errors++; $display("FAIL st_bus got w=%b addr=%h dout=%h want 1/0040/abcd", bus16.W, bus16.ADDR, bus16.DOUT); end
    vectors++; if (done !== 1'b1 || ts !== 3'd3) begin errors++; $display("FAIL st_done got done=%b ts=%0d want 1/3", done, ts); end
    @(negedge clk);
    vectors++; if (bus16.W !== 1'b0 || ts !== 3'd5) begin errors++; $display("FAIL st_w_pulse got w=%b ts=%0d want 0/5", bus16.W, ts); end
    vectors++; if (mem[16'h0040] !== 16'hABCD) begin errors++; $display("FAIL st_mem got %h want abcd", mem[16'h0040]); end
  endtask

  task automatic test_async_reset();
    int b, dc; bit w;
    reset_begin();
    load(16'd0, enc(3'd1, 3'd1, 3'd0)); load(16'd1, 16'd7);
    load(16'd2, enc(3'd1, 3'd2, 3'd0)); load(16'd3, 16'd9);
    load(16'd4, enc(3'd2, 3'd1, 3'd2));
    reset_end();
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin model_step(b, w); exec_instr(0, 0, dc); end
    dinv = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    vectors++; if (ts !== 3'd3) begin errors++; $display("FAIL add_in_ex2 got ts=%0d want 3", ts); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (ts !== 3'd5 || done !== 1'b0) begin errors++; $display("FAIL async_state got ts=%0d done=%b want 5/0", ts, done); end
    vectors++; if (u_dut.r_q[1] !== 16'd0 || u_dut.r_q[2] !== 16'd0 || r0 !== 16'd0 || u_dut.a_q !== 16'd0) begin
      errors++; $display("FAIL async_regs got r1=%h r2=%h r0=%h a=%h want 0", u_dut.r_q[1], u_dut.r_q[2], r0, u_dut.a_q); end
    vectors++; if (bus16.ADDR !== 16'd0) begin errors++; $display("FAIL async_addr got %h want 0", bus16.ADDR); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mr[i] = 16'd0;
    mz = 1'b0;
  endtask

  task automatic test_wrap9();
    reset_begin();
    for (int i = 0; i < 512; i++) mem9[i] = 9'd0;
    mem9[0] = 9'h040;
    mem9[1] = 9'h1FF;
    reset_end();
    run9 = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (r0_9 !== 9'h1FF) begin errors++; $display("FAIL wrap_setup got %h want 1ff", r0_9); end
    @(negedge clk);
    vectors++; if (r0_9 !== 9'h000 || bus9.ADDR !== 9'h1FF || ts9 !== 3'd1) begin
      errors++; $display("FAIL wrap_r0 got r0=%h addr=%h ts=%0d want 000/1ff/1", r0_9, bus9.ADDR, ts9); end
    run9 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_op7();
    int b, dc; bit w;
    reset_begin();
    load(16'd0, enc(3'd1, 3'd1, 3'd0)); load(16'd1, 16'h00F0);
    load(16'd2, enc(3'd1, 3'd2, 3'd0)); load(16'd3, 16'h0F0F);
    load(16'd4, enc(3'd7, 3'd1, 3'd2));
    reset_end();
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin model_step(b, w); exec_instr(0, 0, dc); end
`ifdef PROC_AND_EN
    vectors++; if (dc !== 5) begin errors++; $display("FAIL and_latency got %0d want 5", dc); end
    vectors++; if (u_dut.r_q[1] !== 16'h0000 || u_dut.z_q !== 1'b1) begin
      errors++; $display("FAIL and_result got r1=%h z=%b want 0000/1", u_dut.r_q[1], u_dut.z_q); end
`else
    vectors++; if (dc !== 3) begin errors++; $display("FAIL nop_latency got %0d want 3", dc); end
    vectors++; if (u_dut.r_q[1] !== 16'h00F0 || u_dut.z_q !== 1'b0) begin
      errors++; $display("FAIL nop_result got r1=%h z=%b want 00f0/0", u_dut.r_q[1], u_dut.z_q); end
`endif
  endtask

  task automatic test_random();
    int b, dc, k1, k2; bit w;
    logic [15:0] wd;
    reset_begin();
    for (int a = 0; a < 128; a++) begin
      wd = 16'($urandom);
      if (wd[5:3] == 3'd0) wd[5:3] = 3'd1;
      load(16'(a), wd);
    end
    reset_end();
    st_q.delete();
    run = 1'b1;
    for (int n = 0; n < 60; n++) begin
      model_step(b, w);
      k1 = $urandom_range(0, 2); k2 = $urandom_range(0, 2);
      exec_instr(k1, k2, dc);
      vectors++; if (dc !== b + k1 + (w ? k2 : 0)) begin
        errors++; $display("FAIL rand_latency n%0d got %0d want %0d", n, dc, b + k1 + (w ? k2 : 0)); end
      vectors++; if (r0 !== mr[0]) begin errors++; $display("FAIL rand_pc n%0d got %h want %h", n, r0, mr[0]); end
      for (int r = 1; r < 8; r++) begin
        vectors++; if (u_dut.r_q[r] !== mr[r]) begin
          errors++; $display("FAIL rand_reg n%0d R%0d got %h want %h", n, r, u_dut.r_q[r], mr[r]); end
      end
      vectors++; if (u_dut.z_q !== mz) begin errors++; $display("FAIL rand_z n%0d got %b want %b", n, u_dut.z_q, mz); end
    end
    run = 1'b0;
    repeat (8) @(negedge clk);
    foreach (st_q[i]) begin
      vectors++; if (mem[st_q[i]] !== mm[st_q[i]]) begin
        errors++; $display("FAIL rand_mem @%h got %h want %h", st_q[i], mem[st_q[i]], mm[st_q[i]]); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; run9 = 1'b0; dinv = 1'b0;
    test_reset();
    test_stall();
    test_sub_branch();
    test_store();
    test_async_reset();
    test_wrap9();
    test_op7();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
